msk_inv_pipe: RTL and testbench



---
 rtl/msk_inv_pipe.sv | 56 +++++
 tb/tb_msk_inv_pipe.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/msk_inv_pipe.sv
// Purpose: per-element masked inversion (share 0 XOR public ctrl), carried through a register pipeline.
// Latency: exactly LATENCY enabled clock edges from in/inv_ctrl/in_valid to out/out_valid.
// Backpressure: en=0 freezes every stage; there is no ready handshake and nothing is dropped while stalled.
module msk_inv_pipe #(
   parameter int d       = 2,
   parameter int count   = 1,
   parameter int LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 in_valid,
   input  logic [count-1:0]     inv_ctrl,
   input  logic [count*d-1:0]   in,
   output logic [count*d-1:0]   out,
   output logic                 out_valid,
   output logic                 busy
);

   // Stage-0 result: only share 0 of each element sees its control bit.
   logic [count*d-1:0] f;

   // Per-share register chains; index 1 is fed by f, index LATENCY drives out.
   logic [count*d-1:0] s [1:LATENCY];
   logic [LATENCY:1]   v;

   // Affine step: flipping share 0 inverts the unmasked value without touching other shares.
   always_comb begin
      f = in;
      for (int i = 0; i < count; i++) begin
         f[i*d] = in[i*d] ^ inv_ctrl[i];
      end
   end

   // Pipeline advance; reset dominates en and discards everything in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 1; k <= LATENCY; k++) begin
            s[k] <= '0;
         end
         v <= '0;
      end else if (en) begin
         s[1] <= f;
         v[1] <= in_valid;
         for (int k = 2; k <= LATENCY; k++) begin
            s[k] <= s[k-1];
            v[k] <= v[k-1];
         end
      end
   end

   assign out       = s[LATENCY];
   assign out_valid = v[LATENCY];
   assign busy      = |v;

endmodule

// File: tb/tb_msk_inv_pipe.sv
module tb_msk_inv_pipe;

   logic       clk = 1'b0;
   logic       rst_n;

   // DUT A: d=2, count=2, LATENCY=2
   logic       en_a, in_valid_a;
   logic [1:0] inv_a;
   logic [3:0] in_a;
   logic [3:0] out_a;
   logic       out_valid_a, busy_a;

   // DUT B: d=1, count=4, LATENCY=3
   logic       en_b, in_valid_b;
   logic [3:0] inv_b;
   logic [3:0] in_b;
   logic [3:0] out_b;
   logic       out_valid_b, busy_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   msk_inv_pipe #(.d(2), .count(2), .LATENCY(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .in_valid(in_valid_a),
      .inv_ctrl(inv_a), .in(in_a), .out(out_a), .out_valid(out_valid_a), .busy(busy_a)
   );

   msk_inv_pipe #(.d(1), .count(4), .LATENCY(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .in_valid(in_valid_b),
      .inv_ctrl(inv_b), .in(in_b), .out(out_b), .out_valid(out_valid_b), .busy(busy_b)
   );

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
      in_valid_a = 1'b0; in_a = 4'b0; inv_a = 2'b0;
      in_valid_b = 1'b0; in_b = 4'b0; inv_b = 4'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_a !== 4'b0)       begin errors++; $display("FAIL reset_out_a got %b want 0000", out_a); end
      checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid_a got %b want 0", out_valid_a); end
      checks++; if (busy_a !== 1'b0)      begin errors++; $display("FAIL reset_busy_a got %b want 0", busy_a); end
      checks++; if (out_b !== 4'b0)       begin errors++; $display("FAIL reset_out_b got %b want 0000", out_b); end
      checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL reset_out_valid_b got %b want 0", out_valid_b); end
      checks++; if (busy_b !== 1'b0)      begin errors++; $display("FAIL reset_busy_b got %b want 0", busy_b); end
      rst_n = 1'b1;
   endtask

   // in=1001, inv=01: element0 {s1,s0}=01 -> 00, element1 {s1,s0}=10 unchanged -> 1000
   task automatic test_single();
      @(negedge clk);
      en_a = 1'b1; in_valid_a = 1'b1; in_a = 4'b1001; inv_a = 2'b01;
      @(posedge clk);
      @(negedge clk);
      in_valid_a = 1'b0; in_a = 4'b0; inv_a = 2'b0;
      checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", out_valid_a); end
      checks++; if (busy_a !== 1'b1)      begin errors++; $display("FAIL single_busy1 got %b want 1", busy_a); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_a !== 4'b1000)    begin errors++; $display("FAIL single_out got %b want 1000", out_a); end
      checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid_a); end
      checks++; if (busy_a !== 1'b1)      begin errors++; $display("FAIL single_busy2 got %b want 1", busy_a); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b want 0", out_valid_a); end
      checks++; if (busy_a !== 1'b0)      begin errors++; $display("FAIL single_busy_drop got %b want 0", busy_a); end
      checks++; if (out_a !== 4'b0000)    begin errors++; $display("FAIL single_out_flush got %b want 0000", out_a); end
   endtask

   task automatic test_stall();
      @(negedge clk);
      en_a = 1'b1; in_valid_a = 1'b1; in_a = 4'b1001; inv_a = 2'b01;
      @(posedge clk);
      @(negedge clk);
      in_valid_a = 1'b0; in_a = 4'b0110; inv_a = 2'b11; en_a = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d] got %b want 0", c, out_valid_a); end
         checks++; if (busy_a !== 1'b1)      begin errors++; $display("FAIL stall_busy[%0d] got %b want 1", c, busy_a); end
         checks++; if (out_a !== 4'b0000)    begin errors++; $display("FAIL stall_out_hold[%0d] got %b want 0000", c, out_a); end
      end
      en_a = 1'b1; in_a = 4'b0; inv_a = 2'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_a !== 4'b1000)    begin errors++; $display("FAIL stall_out got %b want 1000", out_a); end
      checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL stall_out_valid got %b want 1", out_valid_a); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL stall_valid_drop got %b want 0", out_valid_a); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] vin  [8];
      logic [1:0] vinv [8];
      logic [3:0] exp_w;
      logic [1:0] exp_x;
      logic [1:0] got_x;
      for (int j = 0; j < 8; j++) begin
         vin[j]  = 4'($urandom_range(0, 15));
         vinv[j] = 2'($urandom_range(0, 3));
      end
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (j >= 2) begin
            exp_w = vin[j-2] ^ {1'b0, vinv[j-2][1], 1'b0, vinv[j-2][0]};
            exp_x[0] = vin[j-2][0] ^ vin[j-2][1] ^ vinv[j-2][0];
            exp_x[1] = vin[j-2][2] ^ vin[j-2][3] ^ vinv[j-2][1];
            got_x = {out_a[2] ^ out_a[3], out_a[0] ^ out_a[1]};
            checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", j-2, out_valid_a); end
            checks++; if (got_x !== exp_x)      begin errors++; $display("FAIL b2b_unmasked[%0d] got %b want %b", j-2, got_x, exp_x); end
            checks++; if (out_a !== exp_w)      begin errors++; $display("FAIL b2b_shares[%0d] got %b want %b", j-2, out_a, exp_w); end
         end
         if (j < 8) begin
            en_a = 1'b1; in_valid_a = 1'b1; in_a = vin[j]; inv_a = vinv[j];
         end else begin
            in_valid_a = 1'b0; in_a = 4'b0; inv_a = 2'b0;
         end
         @(posedge clk);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      en_a = 1'b1; in_valid_a = 1'b1; in_a = 4'b0011; inv_a = 2'b10;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0; in_valid_a = 1'b0; in_a = 4'b0; inv_a = 2'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (busy_a !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b want 0", busy_a); end
      checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid_a); end
      checks++; if (out_a !== 4'b0000)    begin errors++; $display("FAIL midrst_out got %b want 0000", out_a); end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL midrst_after_valid[%0d] got %b want 0", c, out_valid_a); end
      end
   endtask

   // d=1: every bit is its own element, so inv=1111 flips all: 0101 -> 1010
   task automatic test_d1();
      @(negedge clk);
      en_b = 1'b1; in_valid_b = 1'b1; in_b = 4'b0101; inv_b = 4'b1111;
      @(posedge clk);
      @(negedge clk);
      in_valid_b = 1'b0; in_b = 4'b0; inv_b = 4'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL d1_early_valid got %b want 0", out_valid_b); end
      checks++; if (busy_b !== 1'b1)      begin errors++; $display("FAIL d1_busy got %b want 1", busy_b); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_b !== 4'b1010)    begin errors++; $display("FAIL d1_out got %b want 1010", out_b); end
      checks++; if (out_valid_b !== 1'b1) begin errors++; $display("FAIL d1_valid got %b want 1", out_valid_b); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL d1_valid_drop got %b want 0", out_valid_b); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      en_a = 1'b0; in_valid_a = 1'b0; in_a = 4'b0; inv_a = 2'b0;
      en_b = 1'b0; in_valid_b = 1'b0; in_b = 4'b0; inv_b = 4'b0;
      test_reset();
      test_single();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_d1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
